// File: rtl/stride_read_scheduler_if.sv
// Bus bundle between the strided-read scheduler and its job controller / scratchpad consumer.
// The scheduler side takes the slave modport; the controller side takes master.
interface stride_read_scheduler_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] start_ptr;
    logic [ADDR_WIDTH-1:0] stride_step;
    logic [CNT_WIDTH-1:0]  num_strides;
    logic [ADDR_WIDTH-1:0] end_ptr;
    logic                  ep_valid;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  rd_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  stride_ended;
    logic [CNT_WIDTH-1:0]  stride_idx;
    logic [ADDR_WIDTH-1:0] free_ptr;
    logic                  busy;
    logic                  done;

    modport slave (
        input  start, abort, start_ptr, stride_step, num_strides,
        input  end_ptr, ep_valid, wr_ptr, rd_ready,
        output rd_en, rd_addr, stride_ended, stride_idx, free_ptr, busy, done
    );

    modport master (
        output start, abort, start_ptr, stride_step, num_strides,
        output end_ptr, ep_valid, wr_ptr, rd_ready,
        input  rd_en, rd_addr, stride_ended, stride_idx, free_ptr, busy, done
    );
endinterface

// File: rtl/stride_read_scheduler.sv
// Walks strided reads through a circular scratchpad, stalling on the writer pointer,
// pulsing at every stride end and exporting the oldest live address for reclaim.
module stride_read_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    stride_read_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [CNT_WIDTH-1:0]  strideIdx_q, strideIdx_d;
    logic [CNT_WIDTH-1:0]  numStrides_q, numStrides_d;
    logic                  ended_q, ended_d;

    logic                  rdEn;
    logic                  fire;
    logic                  strideEnd;
    logic [ADDR_WIDTH-1:0] nextBase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            cur_q        <= '0;
            strideIdx_q  <= '0;
            numStrides_q <= '0;
            ended_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cur_q        <= cur_d;
            strideIdx_q  <= strideIdx_d;
            numStrides_q <= numStrides_d;
            ended_q      <= ended_d;
        end
    end

    // An end pointer only terminates the stride once the producer has marked it final.
    assign fire      = rdEn && bus.rd_ready;
    assign strideEnd = fire && bus.ep_valid && (cur_q == bus.end_ptr);
    assign nextBase  = base_q + bus.stride_step;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cur_d        = cur_q;
        strideIdx_d  = strideIdx_q;
        numStrides_d = numStrides_q;
        ended_d      = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        base_d       = bus.start_ptr;
                        cur_d        = bus.start_ptr;
                        strideIdx_d  = '0;
                        numStrides_d = bus.num_strides;
                        state_d      = (bus.num_strides == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (strideEnd) begin
                        ended_d = 1'b1;
                        if (strideIdx_q == numStrides_q - CNT_ONE) begin
                            state_d = DONE;
                        end else begin
                            base_d      = nextBase;
                            cur_d       = nextBase;
                            strideIdx_d = strideIdx_q + CNT_ONE;
                        end
                    end else if (fire) begin
                        cur_d = cur_q + ADDR_ONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // cur == wr_ptr means nothing unread is left, so the request is withheld.
    always_comb begin
        rdEn             = (state_q == READ) && (cur_q != bus.wr_ptr) && !bus.abort;
        bus.rd_en        = rdEn;
        bus.rd_addr      = cur_q;
        bus.stride_ended = ended_q;
        bus.stride_idx   = strideIdx_q;
        bus.free_ptr     = base_q;
        bus.busy         = (state_q == READ) || (state_q == DONE);
        bus.done         = (state_q == DONE);
    end
endmodule

// File: tb/tb_stride_read_scheduler.sv
// Self-checking bench for stride_read_scheduler: a monitor logs every accepted read,
// and each scenario task compares the log against the addresses it expected.
module tb_stride_read_scheduler;
    logic clk;
    logic rst_n;

    stride_read_scheduler_if #(.ADDR_WIDTH(8), .CNT_WIDTH(8)) bus ();

    stride_read_scheduler #(.ADDR_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] expAddrQ[$];
    logic [7:0] expIdxQ[$];
    logic [7:0] expFreeQ[$];
    logic [7:0] obsAddrQ[$];
    logic [7:0] obsIdxQ[$];
    logic [7:0] obsFreeQ[$];
    int endCount;
    int doneCount;
    int doneWithEnd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor samples mid-cycle, when inputs driven after the rising edge have settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd_en && bus.rd_ready) begin
                obsAddrQ.push_back(bus.rd_addr);
                obsIdxQ.push_back(bus.stride_idx);
                obsFreeQ.push_back(bus.free_ptr);
            end
            if (bus.stride_ended) endCount++;
            if (bus.done) begin
                doneCount++;
                if (bus.stride_ended) doneWithEnd++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearScoreboard();
        expAddrQ.delete(); expIdxQ.delete(); expFreeQ.delete();
        obsAddrQ.delete(); obsIdxQ.delete(); obsFreeQ.delete();
        endCount = 0; doneCount = 0; doneWithEnd = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] sp, input logic [7:0] step, input logic [7:0] num,
                                 input logic [7:0] ep, input logic epv, input logic [7:0] wr);
        clearScoreboard();
        bus.start_ptr   = sp;
        bus.stride_step = step;
        bus.num_strides = num;
        bus.end_ptr     = ep;
        bus.ep_valid    = epv;
        bus.wr_ptr      = wr;
        bus.rd_ready    = 1'b1;
        bus.abort       = 1'b0;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 0; bus.abort = 0; bus.start_ptr = 0; bus.stride_step = 0;
        bus.num_strides = 0; bus.end_ptr = 0; bus.ep_valid = 0; bus.wr_ptr = 0; bus.rd_ready = 0;
        #2;
        checks++;
        if ({bus.rd_en, bus.rd_addr, bus.stride_ended, bus.stride_idx, bus.free_ptr, bus.busy, bus.done} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {bus.rd_en, bus.rd_addr, bus.stride_ended, bus.stride_idx, bus.free_ptr, bus.busy, bus.done});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_stride();
        applyStimulus(8'h10, 8'h00, 8'd1, 8'h13, 1'b1, 8'h20);
        for (int i = 0; i < 4; i++) begin
            expAddrQ.push_back(8'(8'h10 + i));
            @(negedge clk);
            checks++;
            if (bus.rd_en !== 1'b1 || bus.rd_addr !== 8'(8'h10 + i)) begin
                errors++;
                $display("[TB] FAIL single_cycle%0d: got en=%b addr=%h required en=1 addr=%h",
                         i, bus.rd_en, bus.rd_addr, 8'(8'h10 + i));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.stride_ended !== 1'b1 || bus.done !== 1'b1 || bus.rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_end: got ended=%b done=%b en=%b required 1 1 0",
                     bus.stride_ended, bus.done, bus.rd_en);
        end
        tick();
        tick();
        checks++;
        if (obsAddrQ.size() != expAddrQ.size()) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d reads required %0d", obsAddrQ.size(), expAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            logic [7:0] e, o;
            e = expAddrQ.pop_front();
            o = obsAddrQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL single_addr: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_wrap();
        bit seen;
        applyStimulus(8'hFE, 8'h00, 8'd1, 8'h01, 1'b1, 8'h05);
        expAddrQ.push_back(8'hFE); expAddrQ.push_back(8'hFF);
        expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h01);
        waitDone(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL wrap_timeout: got no done required done within 20 cycles");
        end
        checks++;
        if (endCount != 1) begin
            errors++;
            $display("[TB] FAIL wrap_ended: got %0d pulses required 1", endCount);
        end
        checks++;
        if (obsAddrQ.size() != expAddrQ.size()) begin
            errors++;
            $display("[TB] FAIL wrap_count: got %0d reads required %0d", obsAddrQ.size(), expAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            logic [7:0] e, o;
            e = expAddrQ.pop_front();
            o = obsAddrQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL wrap_addr: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_multi_stride();
        bit seen;
        applyStimulus(8'h00, 8'h04, 8'd3, 8'h03, 1'b1, 8'h20);
        for (int s = 0; s < 3; s++) begin
            for (int a = 0; a < 4; a++) begin
                expAddrQ.push_back(8'(4 * s + a));
                expIdxQ.push_back(8'(s));
                expFreeQ.push_back(8'(4 * s));
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            bus.end_ptr = 8'(4 * endCount + 3);
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
            tick();
        end
        tick();
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL multi_timeout: got no done required done within 60 cycles");
        end
        checks++;
        if (endCount != 3 || doneCount != 1 || doneWithEnd != 1) begin
            errors++;
            $display("[TB] FAIL multi_pulses: got ended=%0d done=%0d coincident=%0d required 3 1 1",
                     endCount, doneCount, doneWithEnd);
        end
        checks++;
        if (obsAddrQ.size() != expAddrQ.size()) begin
            errors++;
            $display("[TB] FAIL multi_count: got %0d reads required %0d", obsAddrQ.size(), expAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            logic [7:0] e, o, ei, oi, ef, of;
            e  = expAddrQ.pop_front(); o  = obsAddrQ.pop_front();
            ei = expIdxQ.pop_front();  oi = obsIdxQ.pop_front();
            ef = expFreeQ.pop_front(); of = obsFreeQ.pop_front();
            checks++;
            if (o !== e || oi !== ei || of !== ef) begin
                errors++;
                $display("[TB] FAIL multi_read: got addr=%h idx=%h free=%h required addr=%h idx=%h free=%h",
                         o, oi, of, e, ei, ef);
            end
        end
    endtask

    task automatic test_stall();
        bit seen;
        applyStimulus(8'h10, 8'h00, 8'd1, 8'h14, 1'b1, 8'h12);
        for (int i = 0; i < 5; i++) expAddrQ.push_back(8'(8'h10 + i));
        @(negedge clk); tick();
        @(negedge clk); tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rd_en !== 1'b0 || bus.rd_addr !== 8'h12) begin
                errors++;
                $display("[TB] FAIL stall_empty: got en=%b addr=%h required en=0 addr=12", bus.rd_en, bus.rd_addr);
            end
            tick();
        end
        bus.wr_ptr   = 8'h13;
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rd_en !== 1'b1 || bus.rd_addr !== 8'h12) begin
                errors++;
                $display("[TB] FAIL stall_notready: got en=%b addr=%h required en=1 addr=12", bus.rd_en, bus.rd_addr);
            end
            tick();
        end
        bus.rd_ready = 1'b1;
        tick();
        bus.wr_ptr = 8'h20;
        waitDone(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL stall_timeout: got no done required done within 20 cycles");
        end
        checks++;
        if (obsAddrQ.size() != expAddrQ.size()) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d reads required %0d", obsAddrQ.size(), expAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            logic [7:0] e, o;
            e = expAddrQ.pop_front();
            o = obsAddrQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL stall_addr: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_ep_valid();
        bit seen;
        applyStimulus(8'h10, 8'h00, 8'd1, 8'h11, 1'b0, 8'h20);
        for (int i = 0; i < 5; i++) expAddrQ.push_back(8'(8'h10 + i));
        @(negedge clk); tick();
        @(negedge clk); tick();
        @(negedge clk);
        checks++;
        if (bus.rd_addr !== 8'h12 || bus.stride_ended !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ep_not_final: got addr=%h ended=%b required addr=12 ended=0",
                     bus.rd_addr, bus.stride_ended);
        end
        tick();
        bus.ep_valid = 1'b1;
        bus.end_ptr  = 8'h14;
        waitDone(20, seen);
        checks++;
        if (!seen || endCount != 1) begin
            errors++;
            $display("[TB] FAIL ep_end: got done=%b ended=%0d required done=1 ended=1", seen, endCount);
        end
        checks++;
        if (obsAddrQ.size() != expAddrQ.size()) begin
            errors++;
            $display("[TB] FAIL ep_count: got %0d reads required %0d", obsAddrQ.size(), expAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            logic [7:0] e, o;
            e = expAddrQ.pop_front();
            o = obsAddrQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL ep_addr: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_abort();
        applyStimulus(8'h10, 8'h04, 8'd2, 8'h14, 1'b1, 8'h20);
        expAddrQ.push_back(8'h10);
        @(negedge clk);
        tick();
        bus.abort = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rd_en !== 1'b0 || bus.rd_addr !== 8'h11) begin
            errors++;
            $display("[TB] FAIL abort_gate: got en=%b addr=%h required en=0 addr=11", bus.rd_en, bus.rd_addr);
        end
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.done !== 1'b0 || bus.stride_ended !== 1'b0 ||
            bus.free_ptr !== 8'h10 || bus.stride_idx !== 8'h00) begin
            errors++;
            $display("[TB] FAIL abort_idle: got busy=%b en=%b done=%b ended=%b free=%h idx=%h required 0 0 0 0 10 00",
                     bus.busy, bus.rd_en, bus.done, bus.stride_ended, bus.free_ptr, bus.stride_idx);
        end
        tick();
        tick();
        checks++;
        if (doneCount != 0 || endCount != 0 || obsAddrQ.size() != 1) begin
            errors++;
            $display("[TB] FAIL abort_pulses: got done=%0d ended=%0d reads=%0d required 0 0 1",
                     doneCount, endCount, obsAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            logic [7:0] e, o;
            e = expAddrQ.pop_front();
            o = obsAddrQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL abort_addr: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit seen;
        applyStimulus(8'h10, 8'h00, 8'd1, 8'h12, 1'b1, 8'h20);
        for (int i = 0; i < 3; i++) begin
            expAddrQ.push_back(8'(8'h10 + i));
            expFreeQ.push_back(8'h10);
        end
        bus.start       = 1'b1;
        bus.start_ptr   = 8'h40;
        bus.num_strides = 8'd5;
        @(negedge clk);
        tick();
        bus.start = 1'b0;
        waitDone(20, seen);
        checks++;
        if (!seen || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL ignore_done: got done=%b count=%0d required done=1 count=1", seen, doneCount);
        end
        checks++;
        if (obsAddrQ.size() != expAddrQ.size()) begin
            errors++;
            $display("[TB] FAIL ignore_count: got %0d reads required %0d", obsAddrQ.size(), expAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            logic [7:0] e, o, ef, of;
            e  = expAddrQ.pop_front(); o  = obsAddrQ.pop_front();
            ef = expFreeQ.pop_front(); of = obsFreeQ.pop_front();
            checks++;
            if (o !== e || of !== ef) begin
                errors++;
                $display("[TB] FAIL ignore_read: got addr=%h free=%h required addr=%h free=%h", o, of, e, ef);
            end
        end
    endtask

    task automatic test_empty_job();
        applyStimulus(8'h30, 8'h00, 8'd0, 8'h00, 1'b0, 8'h50);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.rd_en !== 1'b0 || bus.free_ptr !== 8'h30) begin
            errors++;
            $display("[TB] FAIL empty_done: got done=%b busy=%b en=%b free=%h required 1 1 0 30",
                     bus.done, bus.busy, bus.rd_en, bus.free_ptr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || obsAddrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL empty_idle: got done=%b busy=%b reads=%0d required 0 0 0",
                     bus.done, bus.busy, obsAddrQ.size());
        end
        tick();
    endtask

    task automatic test_reset_mid_job();
        applyStimulus(8'h50, 8'h00, 8'd1, 8'h5F, 1'b1, 8'h60);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rd_en, bus.rd_addr, bus.stride_ended, bus.stride_idx, bus.free_ptr, bus.busy, bus.done} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_job: got %h required 0",
                     {bus.rd_en, bus.rd_addr, bus.stride_ended, bus.stride_idx, bus.free_ptr, bus.busy, bus.done});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        clearScoreboard();
        test_reset();
        test_single_stride();
        test_wrap();
        test_multi_stride();
        test_stall();
        test_ep_valid();
        test_abort();
        test_start_ignored();
        test_empty_job();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
